// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the 2-bit adder, the sum accumulator and its result consumer.
// Latency: none, pure wiring.
// Backpressure: carries in_ready and out_ready; the bundle does no flow control itself.
interface sum_accumulator_if #(
  parameter int ACC_W = 8,
  parameter int BATCH = 4
);
  localparam int CNT_W = ($clog2(BATCH + 1) > 1) ? $clog2(BATCH + 1) : 1;

  logic             in_valid;
  logic             in_ready;
  logic             sum0;
  logic             sum1;
  logic             sum2;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic [CNT_W-1:0] sample_cnt;

  // The producer/consumer side drives samples, clear and out_ready.
  modport master (
    output in_valid, sum0, sum1, sum2, clear, out_ready,
    input  in_ready, out_valid, acc_out, overflow, sample_cnt
  );

  // The accumulator side.
  modport slave (
    input  in_valid, sum0, sum1, sum2, clear, out_ready,
    output in_ready, out_valid, acc_out, overflow, sample_cnt
  );
endinterface

// File: rtl/sum_accumulator.sv
// Sums BATCH 3-bit adder results into an ACC_W-bit total with a sticky overflow flag.
// Latency: out_valid rises the cycle after the BATCH-th sample is accepted.
// Backpressure: in_ready drops while a finished total waits; the total is held until out_ready.
module sum_accumulator #(
  parameter int ACC_W = 8,
  parameter int BATCH = 4
) (
  input logic               clk,
  input logic               rst_n,
  sum_accumulator_if.slave  bus
);
  localparam int CNT_W = ($clog2(BATCH + 1) > 1) ? $clog2(BATCH + 1) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_vld_q;

  logic             accept;
  logic [2:0]       sample;
  logic [ACC_W:0]   sum_ext;
  logic             last_sample;

  // Sample is zero-extended one bit past the accumulator so the top bit is the carry out.
  assign sample      = {bus.sum2, bus.sum1, bus.sum0};
  assign sum_ext     = {1'b0, acc_q} + {{(ACC_W - 2){1'b0}}, sample};
  assign accept      = bus.in_valid & (state == ACCUM);
  assign last_sample = (cnt_q == CNT_W'(BATCH - 1));

  assign bus.in_ready   = (state == ACCUM);
  assign bus.out_valid  = out_vld_q;
  assign bus.acc_out    = acc_q;
  assign bus.overflow   = ovf_q;
  assign bus.sample_cnt = cnt_q;

  // Batch state machine: clear has priority over accepts and the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (bus.clear) begin
      state     <= ACCUM;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_q <= sum_ext[ACC_W-1:0];
            ovf_q <= ovf_q | sum_ext[ACC_W];
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_sample) begin
              state     <= DONE;
              out_vld_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= ACCUM;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed batches with hand-computed totals on two parameterisations.
// Expected results are queued at stimulus time and popped by monitors on each result handshake.
// Direct spot checks cover reset values, latency, backpressure holding and clear.
module tb_sum_accumulator;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.ACC_W(8), .BATCH(4)) bus ();
  sum_accumulator_if #(.ACC_W(4), .BATCH(4)) bus4 ();

  sum_accumulator #(.ACC_W(8), .BATCH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sum_accumulator #(.ACC_W(4), .BATCH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int checks = 0;
  int errors = 0;

  int exp_acc[$];
  int exp_ovf[$];
  int exp4_acc[$];
  int exp4_ovf[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance: every result handshake must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_acc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got acc %0d, expected no result at %0t", bus.acc_out, $time);
      end else begin
        chk("result_acc", bus.acc_out, exp_acc.pop_front());
        chk("result_ovf", bus.overflow, exp_ovf.pop_front());
        chk("result_cnt", bus.sample_cnt, 4);
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (exp4_acc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result4: got acc %0d, expected no result at %0t", bus4.acc_out, $time);
      end else begin
        chk("result4_acc", bus4.acc_out, exp4_acc.pop_front());
        chk("result4_ovf", bus4.overflow, exp4_ovf.pop_front());
      end
    end
  end

  // Drives one sample for one cycle; inputs change 1 time unit after the rising edge.
  task automatic send(input int v);
    bus.in_valid = 1'b1;
    {bus.sum2, bus.sum1, bus.sum0} = 3'(v);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send4(input int v);
    bus4.in_valid = 1'b1;
    {bus4.sum2, bus4.sum1, bus4.sum0} = 3'(v);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input int acc, input int ovf);
    exp_acc.push_back(acc);
    exp_ovf.push_back(ovf);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.sum0       = 1'b0;
    bus.sum1       = 1'b0;
    bus.sum2       = 1'b0;
    bus.clear      = 1'b0;
    bus.out_ready  = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.sum0      = 1'b0;
    bus4.sum1      = 1'b0;
    bus4.sum2      = 1'b0;
    bus4.clear     = 1'b0;
    bus4.out_ready = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_acc", bus.acc_out, 0);
    chk("rst_cnt", bus.sample_cnt, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back batch 3+6+5+1 = 15
    push(15, 0);
    send(3); send(6); send(5); send(1);
    chk("b2b_out_valid", bus.out_valid, 1);
    chk("b2b_acc", bus.acc_out, 15);
    chk("b2b_cnt", bus.sample_cnt, 4);
    chk("b2b_in_ready_done", bus.in_ready, 0);
    idle(1);
    chk("b2b_out_valid_drop", bus.out_valid, 0);
    chk("b2b_acc_cleared", bus.acc_out, 0);
    chk("b2b_in_ready_back", bus.in_ready, 1);

    // Same batch with gaps in in_valid
    push(15, 0);
    send(3);
    send(6); idle(1);
    chk("gap_cnt2", bus.sample_cnt, 2);
    chk("gap_acc9", bus.acc_out, 9);
    send(5); idle(3);
    chk("gap_cnt3", bus.sample_cnt, 3);
    send(1);
    chk("gap_out_valid", bus.out_valid, 1);
    idle(1);

    // Backpressure: total held, sample 7 not absorbed while done
    bus.out_ready = 1'b0;
    push(15, 0);
    send(3); send(6); send(5); send(1);
    bus.in_valid = 1'b1;
    {bus.sum2, bus.sum1, bus.sum0} = 3'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_acc_hold", bus.acc_out, 15);
      chk("bp_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_cnt", bus.sample_cnt, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_new_cnt", bus.sample_cnt, 1);
    chk("bp_new_acc", bus.acc_out, 7);
    push(10, 0);
    send(1); send(1); send(1);
    idle(1);

    // 4-bit accumulator: 6+6+6+0 = 18 -> 2 with overflow, then 1+1+1+1 = 4 clean
    exp4_acc.push_back(2);
    exp4_ovf.push_back(1);
    exp4_acc.push_back(4);
    exp4_ovf.push_back(0);
    send4(6); send4(6);
    chk("w4_ovf_before", bus4.overflow, 0);
    send4(6);
    chk("w4_ovf_sticky", bus4.overflow, 1);
    send4(0);
    chk("w4_acc", bus4.acc_out, 2);
    idle(1);
    send4(1); send4(1); send4(1); send4(1);
    chk("w4_acc2", bus4.acc_out, 4);
    chk("w4_ovf2", bus4.overflow, 0);
    idle(1);

    // Clear with a simultaneous valid sample
    send(5); send(5);
    chk("clr_pre_acc", bus.acc_out, 10);
    chk("clr_pre_cnt", bus.sample_cnt, 2);
    bus.in_valid = 1'b1;
    {bus.sum2, bus.sum1, bus.sum0} = 3'd7;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_acc", bus.acc_out, 0);
    chk("clr_cnt", bus.sample_cnt, 0);
    push(10, 0);
    send(1); send(2); send(3); send(4);
    idle(1);

    // Async reset mid-batch
    send(7); send(7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mid_acc", bus.acc_out, 0);
    chk("arst_mid_cnt", bus.sample_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Async reset while a result waits
    bus.out_ready = 1'b0;
    send(7); send(7); send(7); send(7);
    chk("arst_done_pre", bus.acc_out, 28);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done_valid", bus.out_valid, 0);
    chk("arst_done_acc", bus.acc_out, 0);
    chk("arst_done_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    push(28, 0);
    send(7); send(7); send(7); send(7);
    chk("final_acc", bus.acc_out, 28);
    idle(3);

    chk("queue_drained", exp_acc.size(), 0);
    chk("queue4_drained", exp4_acc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Downstream consumer of the 2-bit parallel adder. It accepts the adder's 3-bit result (sum2..sum0) through a valid/ready handshake and accumulates BATCH samples into an ACC_W-bit total. It then presents the total on an output handshake. The result holds until taken, after which the block starts a fresh batch.

Parameters:
ACC_W, 8, accumulator/result width in bits (>= 3)
BATCH, 4, samples summed per result (>= 1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  sum0..sum2 carry a valid sample
in_ready  output  1  block can accept a sample this cycle
sum0  input  1  adder result bit 0
sum1  input  1  adder result bit 1
sum2  input  1  adder result bit 2 (carry)
clear  input  1  synchronous abort/clear of current batch
out_valid  output  1  acc_out holds a completed batch total
out_ready  input  1  consumer takes the result
acc_out  output  ACC_W  batch total, modulo 2^ACC_W
overflow  output  1  total exceeded 2^ACC_W-1 during this batch
sample_cnt  output  max(1,$clog2(BATCH+1))  samples accepted in current batch

Behaviour:
- Reset (rst_n=0, async): state=ACCUM, acc_out=0, sample_cnt=0, overflow=0, out_valid=0. in_ready=1 once rst_n deasserts.
- in_ready is combinational: 1 in ACCUM, 0 in DONE.
- Accept = in_valid & in_ready.
- Sample value = {sum2,sum1,sum0}, zero-extended to ACC_W+1 bits.
- ACCUM state, on accept:
  - acc_out <= (acc_out + sample) mod 2^ACC_W.
  - overflow <= overflow | carry out of bit ACC_W-1 (sticky within the batch).
  - sample_cnt <= sample_cnt+1.
- ACCUM state, batch completion: if the accept is sample number BATCH (sample_cnt==BATCH-1 before the edge), the same edge also sets state=DONE and out_valid=1.
  - Latency: out_valid is high the cycle after the final sample is accepted.
- ACCUM state, no accept: all state held. Gaps in in_valid are allowed and do not reset the count.
- DONE state:
  - out_valid=1; acc_out, overflow and sample_cnt (=BATCH) held stable.
  - Held while out_ready=0; in_valid is ignored.
- DONE state, out_valid & out_ready at an edge:
  - acc_out<=0, overflow<=0, sample_cnt<=0, out_valid<=0, state=ACCUM.
  - No sample can be accepted in that same cycle, because in_ready=0.
- clear=1 at an edge, in any state:
  - acc_out<=0, overflow<=0, sample_cnt<=0, out_valid<=0, state=ACCUM.
  - clear beats a simultaneous accept or out handshake. The sample is dropped and a pending result is discarded.
- BATCH=1: every accept goes straight to DONE.
- Reset mid-batch or in DONE: immediate return to reset values, with no partial result emitted.
- Outputs other than in_ready are registered.

Test Plan:
- Reset, then samples 3,6,5,1 with in_valid every cycle, out_ready=1 → out_valid rises one cycle after the 4th accept with acc_out=15, overflow=0, sample_cnt=4. It drops next cycle, then acc_out=0 and in_ready=1.
- Same four samples with in_valid gaps of 0-3 cycles → identical result 15. sample_cnt increments only on accepts.
- Backpressure: complete a batch (total 15) with out_ready=0 for 5 cycles while in_valid=1 and sum=7 → in_ready=0, acc_out stays 15, no sample absorbed. The sample on the first cycle after out_ready is taken is counted in the new batch.
- ACC_W=4, BATCH=4, samples 6,6,6,0 → acc_out=2, overflow=1. The next batch of 1,1,1,1 gives acc_out=4, overflow=0.
- clear after 2 samples (5,5) with a simultaneous valid 7 → acc_out=0, sample_cnt=0, the 7 is dropped. The next batch of 1,2,3,4 gives 10.
- rst_n pulsed low asynchronously mid-batch and again while in DONE → outputs go to reset values immediately, with no out_valid pulse. The next full batch of 7,7,7,7 gives 28.
